// File: rtl/jt12_timer_regs.sv
// CPU-side register front end for the FM timer pair.
// Decodes YM2612-style bus writes (address latch + data, part I/II) into the timer
// control registers 0x24..0x27, returns the status byte and generates write-busy.
// Optional CSM key-on generation is enabled by defining JT12_TREGS_CSM_EN; without it
// csm_keyon is tied low and no CSM logic is built.

module jt12_timer_regs #(
  parameter int unsigned BUSY_CYCLES = 32,
  parameter int unsigned BUSY_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       cpu_cs_n,
  input  logic       cpu_wr_n,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  input  logic       flag_A,
  input  logic       flag_B,
  input  logic       overflow_A,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic       enable_irq_A,
  output logic       enable_irq_B,
  output logic [1:0] ch3_mode,
  output logic       busy,
  output logic       csm_keyon
);

  localparam logic [BUSY_W-1:0] BusyLoad = BUSY_W'(BUSY_CYCLES);
  localparam logic [BUSY_W-1:0] BusyOne  = BUSY_W'(1);

  // Bus strobe edge detection
  logic wr_act;
  logic wr_q;
  logic wr_accept;
  logic addr_wr;
  logic data_wr;
  logic data_apply;

  // Address latch
  logic [7:0] reg_addr_q;
  logic       part_q;

  // Timer control registers
  logic [9:0] value_a_q;
  logic [7:0] value_b_q;
  logic       load_a_q;
  logic       load_b_q;
  logic       clr_a_q;
  logic       clr_b_q;
  logic       irq_a_q;
  logic       irq_b_q;
  logic [1:0] ch3_mode_q;

  // Busy window
  logic              busy_q;
  logic              busy_d;
  logic [BUSY_W-1:0] busy_cnt_q;
  logic [BUSY_W-1:0] busy_cnt_d;

  // Status byte
  logic [7:0] dout_q;

  assign wr_act    = ~cpu_cs_n & ~cpu_wr_n;
  // Only the first edge of a strobe counts; a held strobe never repeats the write.
  assign wr_accept = wr_act & ~wr_q;
  assign addr_wr   = wr_accept & ~cpu_addr[0];
  assign data_wr   = wr_accept & cpu_addr[0];
  // Timer registers live in part I only, at 0x24..0x27.
  assign data_apply = data_wr & ~cpu_addr[1] & ~part_q & (reg_addr_q[7:2] == 6'b001001);

  // Registered copy of the strobe for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= 1'b0;
    end else begin
      wr_q <= wr_act;
    end
  end

  // Address latch: even addresses select the register and the part
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_addr_q <= 8'h00;
      part_q     <= 1'b0;
    end else if (addr_wr) begin
      reg_addr_q <= cpu_din;
      part_q     <= cpu_addr[1];
    end
  end

  // Register file for 0x24..0x27; timers start held (load=1) out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_a_q  <= 10'h000;
      value_b_q  <= 8'h00;
      load_a_q   <= 1'b1;
      load_b_q   <= 1'b1;
      irq_a_q    <= 1'b0;
      irq_b_q    <= 1'b0;
      ch3_mode_q <= 2'b00;
    end else if (data_apply) begin
      case (reg_addr_q[1:0])
        2'b00: value_a_q[9:2] <= cpu_din;
        2'b01: value_a_q[1:0] <= cpu_din[1:0];
        2'b10: value_b_q      <= cpu_din;
        default: begin
          ch3_mode_q <= cpu_din[7:6];
          irq_b_q    <= cpu_din[3];
          irq_a_q    <= cpu_din[2];
          load_b_q   <= ~cpu_din[1];
          load_a_q   <= ~cpu_din[0];
        end
      endcase
    end
  end

  // Flag-clear pulses last exactly one clock after the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_a_q <= 1'b0;
      clr_b_q <= 1'b0;
    end else begin
      clr_a_q <= data_apply & (reg_addr_q[1:0] == 2'b11) & cpu_din[4];
      clr_b_q <= data_apply & (reg_addr_q[1:0] == 2'b11) & cpu_din[5];
    end
  end

  // Busy next state: any data write (re)loads the window, even on the final tick
  always_comb begin
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    if (data_wr) begin
      busy_d     = 1'b1;
      busy_cnt_d = BusyLoad;
    end else if (clk_en && busy_q) begin
      if (busy_cnt_q <= BusyOne) begin
        busy_d     = 1'b0;
        busy_cnt_d = '0;
      end else begin
        busy_cnt_d = busy_cnt_q - BusyOne;
      end
    end
  end

  // Busy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Status byte sampled every clock, so it lags busy/flags by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 8'h00;
    end else begin
      dout_q <= {busy_q, 5'b00000, flag_B, flag_A};
    end
  end

`ifdef JT12_TREGS_CSM_EN
  logic csm_q;

  // CSM key-on: timer A overflow on an FM tick while channel 3 is in CSM mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csm_q <= 1'b0;
    end else begin
      csm_q <= clk_en & overflow_A & (ch3_mode_q == 2'b10);
    end
  end

  assign csm_keyon = csm_q;
`else
  logic unused_overflow_a;

  assign unused_overflow_a = overflow_A;
  assign csm_keyon         = 1'b0;
`endif

  assign cpu_dout     = dout_q;
  assign value_A      = value_a_q;
  assign value_B      = value_b_q;
  assign load_A       = load_a_q;
  assign load_B       = load_b_q;
  assign clr_flag_A   = clr_a_q;
  assign clr_flag_B   = clr_b_q;
  assign enable_irq_A = irq_a_q;
  assign enable_irq_B = irq_b_q;
  assign ch3_mode     = ch3_mode_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_jt12_timer_regs.sv
// Scoreboard bench for jt12_timer_regs: stimulus pushes expected values into a queue,
// a negedge monitor pops and compares them against the DUT outputs.

module tb_jt12_timer_regs;

  localparam int SelValueA = 0;
  localparam int SelValueB = 1;
  localparam int SelLoadA  = 2;
  localparam int SelLoadB  = 3;
  localparam int SelClrA   = 4;
  localparam int SelClrB   = 5;
  localparam int SelIrqA   = 6;
  localparam int SelIrqB   = 7;
  localparam int SelCh3    = 8;
  localparam int SelBusy   = 9;
  localparam int SelDout   = 10;
  localparam int SelCsm    = 11;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic       cpu_cs_n;
  logic       cpu_wr_n;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       flag_A;
  logic       flag_B;
  logic       overflow_A;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A;
  logic       load_B;
  logic       clr_flag_A;
  logic       clr_flag_B;
  logic       enable_irq_A;
  logic       enable_irq_B;
  logic [1:0] ch3_mode;
  logic       busy;
  logic       csm_keyon;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] csm_exp;

  jt12_timer_regs #(
    .BUSY_CYCLES(32),
    .BUSY_W     (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .cpu_cs_n    (cpu_cs_n),
    .cpu_wr_n    (cpu_wr_n),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_dout    (cpu_dout),
    .flag_A      (flag_A),
    .flag_B      (flag_B),
    .overflow_A  (overflow_A),
    .value_A     (value_A),
    .value_B     (value_B),
    .load_A      (load_A),
    .load_B      (load_B),
    .clr_flag_A  (clr_flag_A),
    .clr_flag_B  (clr_flag_B),
    .enable_irq_A(enable_irq_A),
    .enable_irq_B(enable_irq_B),
    .ch3_mode    (ch3_mode),
    .busy        (busy),
    .csm_keyon   (csm_keyon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] obs(input int sel);
    case (sel)
      SelValueA: return {6'd0, value_A};
      SelValueB: return {8'd0, value_B};
      SelLoadA:  return {15'd0, load_A};
      SelLoadB:  return {15'd0, load_B};
      SelClrA:   return {15'd0, clr_flag_A};
      SelClrB:   return {15'd0, clr_flag_B};
      SelIrqA:   return {15'd0, enable_irq_A};
      SelIrqB:   return {15'd0, enable_irq_B};
      SelCh3:    return {14'd0, ch3_mode};
      SelBusy:   return {15'd0, busy};
      SelDout:   return {8'd0, cpu_dout};
      default:   return {15'd0, csm_keyon};
    endcase
  endfunction

  // Monitor: every expectation queued before this edge is compared here
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t it;
      logic [15:0] got;
      it  = sb.pop_front();
      got = obs(it.sel);
      n_tests++;
      if (got !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", it.name, got, it.exp);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [15:0] exp);
    exp_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    sb.push_back(it);
  endtask

  // Let the monitor consume the queue; a leftover entry is a failed check
  task automatic drain();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // One-clock bus strobe; returns just after the accepting edge with the strobe released
  task automatic bus_wr(input logic [1:0] addr, input logic [7:0] din, input logic ce);
    @(posedge clk);
    #1;
    cpu_cs_n = 1'b0;
    cpu_wr_n = 1'b0;
    cpu_addr = addr;
    cpu_din  = din;
    clk_en   = ce;
    @(posedge clk);
    #1;
    cpu_cs_n = 1'b1;
    cpu_wr_n = 1'b1;
    clk_en   = 1'b0;
  endtask

  task automatic latch(input logic [7:0] ra);
    bus_wr(2'd0, ra, 1'b0);
  endtask

  task automatic data(input logic [7:0] din);
    bus_wr(2'd1, din, 1'b0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      clk_en = 1'b1;
      @(posedge clk);
      #1;
      clk_en = 1'b0;
    end
  endtask

  task automatic csm_pulse(input logic ce);
    @(posedge clk);
    #1;
    overflow_A = 1'b1;
    clk_en     = ce;
    @(posedge clk);
    #1;
    overflow_A = 1'b0;
    clk_en     = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    clk_en     = 1'b0;
    cpu_cs_n   = 1'b1;
    cpu_wr_n   = 1'b1;
    cpu_addr   = 2'd0;
    cpu_din    = 8'h00;
    flag_A     = 1'b0;
    flag_B     = 1'b0;
    overflow_A = 1'b0;
`ifdef JT12_TREGS_CSM_EN
    csm_exp = 16'd1;
`else
    csm_exp = 16'd0;
`endif

    #12;
    expect_val("rst_value_A", SelValueA, 16'h000);
    expect_val("rst_load_A", SelLoadA, 16'd1);
    expect_val("rst_load_B", SelLoadB, 16'd1);
    expect_val("rst_busy", SelBusy, 16'd0);
    expect_val("rst_dout", SelDout, 16'h00);
    expect_val("rst_csm", SelCsm, 16'd0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Timer A value, high then low bits; status lags busy by one clock
    latch(8'h24);
    data(8'hFF);
    expect_val("value_A_hi", SelValueA, 16'h3FC);
    expect_val("busy_set", SelBusy, 16'd1);
    expect_val("dout_lag", SelDout, 16'h00);
    drain();
    @(posedge clk);
    #1;
    expect_val("dout_busy", SelDout, 16'h80);
    drain();
    latch(8'h25);
    data(8'h02);
    expect_val("value_A_lo", SelValueA, 16'h3FE);
    drain();

    // Part II write to 0x24 must be ignored
    bus_wr(2'd2, 8'h24, 1'b0);
    bus_wr(2'd3, 8'h00, 1'b0);
    expect_val("part2_ignored", SelValueA, 16'h3FE);
    drain();

    latch(8'h26);
    data(8'hA5);
    expect_val("value_B", SelValueB, 16'h0A5);
    drain();

    // Control register 0x27 = 0x15
    latch(8'h27);
    data(8'h15);
    expect_val("ctl_load_A", SelLoadA, 16'd0);
    expect_val("ctl_load_B", SelLoadB, 16'd1);
    expect_val("ctl_irq_A", SelIrqA, 16'd1);
    expect_val("ctl_irq_B", SelIrqB, 16'd0);
    expect_val("ctl_clr_A_on", SelClrA, 16'd1);
    expect_val("ctl_clr_B", SelClrB, 16'd0);
    expect_val("ctl_ch3", SelCh3, 16'd0);
    drain();
    @(posedge clk);
    #1;
    expect_val("ctl_clr_A_off", SelClrA, 16'd0);
    drain();

    // Busy window length and restart
    tick(40);
    expect_val("busy_expired", SelBusy, 16'd0);
    drain();
    latch(8'h26);
    data(8'h11);
    expect_val("busy_wr_value_B", SelValueB, 16'h011);
    drain();
    tick(20);
    expect_val("busy_tick20", SelBusy, 16'd1);
    drain();
    data(8'h22);
    tick(31);
    expect_val("busy_restart_31", SelBusy, 16'd1);
    drain();
    tick(1);
    expect_val("busy_restart_32", SelBusy, 16'd0);
    drain();

    // Data write on the final tick reloads the window
    data(8'h44);
    tick(31);
    expect_val("busy_pre_final", SelBusy, 16'd1);
    drain();
    bus_wr(2'd1, 8'h55, 1'b1);
    expect_val("final_tick_busy", SelBusy, 16'd1);
    expect_val("final_tick_value", SelValueB, 16'h055);
    drain();
    tick(31);
    expect_val("final_reload_31", SelBusy, 16'd1);
    drain();
    tick(1);
    expect_val("final_reload_32", SelBusy, 16'd0);
    drain();

    // Strobe held for 10 clocks: one update, one busy start
    @(posedge clk);
    #1;
    cpu_cs_n = 1'b0;
    cpu_wr_n = 1'b0;
    cpu_addr = 2'd1;
    cpu_din  = 8'h5A;
    @(posedge clk);
    #1;
    cpu_din = 8'h77;
    clk_en  = 1'b1;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    cpu_cs_n = 1'b1;
    cpu_wr_n = 1'b1;
    clk_en   = 1'b0;
    expect_val("held_value_B", SelValueB, 16'h05A);
    expect_val("held_busy", SelBusy, 16'd1);
    drain();
    tick(22);
    expect_val("held_busy_22", SelBusy, 16'd1);
    drain();
    tick(1);
    expect_val("held_busy_23", SelBusy, 16'd0);
    drain();

    // Flags reach the status byte one clock later
    @(posedge clk);
    #1;
    flag_A = 1'b1;
    @(posedge clk);
    #1;
    expect_val("dout_flag_A", SelDout, 16'h01);
    drain();
    flag_A = 1'b0;
    flag_B = 1'b1;
    @(posedge clk);
    #1;
    expect_val("dout_flag_B", SelDout, 16'h02);
    drain();
    flag_B = 1'b0;

    // CSM key-on
    latch(8'h27);
    data(8'h80);
    expect_val("csm_ch3", SelCh3, 16'd2);
    expect_val("csm_load_A", SelLoadA, 16'd1);
    drain();
    csm_pulse(1'b1);
    expect_val("csm_pulse", SelCsm, csm_exp);
    drain();
    @(posedge clk);
    #1;
    expect_val("csm_pulse_end", SelCsm, 16'd0);
    drain();
    csm_pulse(1'b0);
    expect_val("csm_no_clk_en", SelCsm, 16'd0);
    drain();
    data(8'h40);
    csm_pulse(1'b1);
    expect_val("csm_mode1", SelCsm, 16'd0);
    drain();

    // Reset in the middle of a busy window
    latch(8'h24);
    data(8'h80);
    expect_val("pre_rst_value_A", SelValueA, 16'h202);
    expect_val("pre_rst_busy", SelBusy, 16'd1);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    expect_val("mid_rst_busy", SelBusy, 16'd0);
    expect_val("mid_rst_load_A", SelLoadA, 16'd1);
    expect_val("mid_rst_load_B", SelLoadB, 16'd1);
    expect_val("mid_rst_value_A", SelValueA, 16'h000);
    expect_val("mid_rst_dout", SelDout, 16'h00);
    drain();
    rst_n = 1'b1;

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
